sm_rom_reader: RTL and testbench

Instruction-memory dump engine: on a start pulse it reads a range of 32-bit words from the instruction memory read port and transmits them over a UART TX line (8N1). It is the transmit-side counterpart of the UART ROM loader. Host tools use it to read back and verify a downloaded program. It sits inside `sm_top`, beside the ROM writer, sharing the memory's second read port.

---
 rtl/sm_rom_reader_if.sv | 37 +++
 rtl/sm_rom_reader.sv | 201 ++++++++++++++++++++
 tb/tb_sm_rom_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm_rom_reader_if.sv
// sm_rom_reader_if: bus bundle between the instruction-memory dump engine
// and its surroundings (control, memory read port, UART line, status).
//
//   start      request pulse, accepted only while the engine is idle
//   startAddr  first word address, sampled with start
//   lastAddr   last word address (inclusive), sampled with start
//   im_ra      memory read address (driven by the engine)
//   im_rd      memory read data, one cycle after im_ra (synchronous read)
//   uart_out   serial 8N1 transmit line, idle high
//   busy       dump in progress
//   done       one-cycle end-of-dump pulse
//   byteIdx    byte of the current word being sent
//
// Modports: master = the dump engine, slave = the environment around it.
interface sm_rom_reader_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] lastAddr;
  logic [ADDR_W-1:0] im_ra;
  logic [31:0]       im_rd;
  logic              uart_out;
  logic              busy;
  logic              done;
  logic [1:0]        byteIdx;

  modport master (
    input  start, startAddr, lastAddr, im_rd,
    output im_ra, uart_out, busy, done, byteIdx
  );

  modport slave (
    output start, startAddr, lastAddr, im_rd,
    input  im_ra, uart_out, busy, done, byteIdx
  );
endinterface

// File: rtl/sm_rom_reader.sv
// sm_rom_reader: instruction-memory dump engine. On an accepted start it
// reads words startAddr..lastAddr (wrapping modulo 2^ADDR_W) through the
// memory read port and sends each word little-endian as four 8N1 bytes.
//
// Ports:
//   clkIn  clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sm_rom_reader_if.master (start/addresses, memory port, UART, status)
//
// Parameters: ADDR_W (word-address width), BAUD_DIV (clocks per bit, >= 2).
//
// Optional feature: define SM_ROM_READER_CHECKSUM_EN to append one extra
// byte after the last word, the XOR of every byte sent in the dump.
module sm_rom_reader #(
  parameter int ADDR_W   = 11,
  parameter int BAUD_DIV = 868
) (
  input  logic            clkIn,
  input  logic            rst_n,
  sm_rom_reader_if.master bus
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [23:0]       rest_q, rest_d;     // bytes of the word not yet sent
  logic [7:0]        byte_q, byte_d;     // byte on the line, shifted LSB first
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              uart_q, uart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SM_ROM_READER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_phase_q, csum_phase_d;
`endif

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  // uart_d always carries the level of the first cycle of the next state,
  // so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    end_d      = end_q;
    rest_d     = rest_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    uart_d     = uart_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SM_ROM_READER_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        uart_d = 1'b1;
        busy_d = 1'b0;
        // busy_q is still high in the done cycle, so a start there is ignored
        if (bus.start && !busy_q) begin
          addr_d  = bus.startAddr;
          end_d   = bus.lastAddr;
          busy_d  = 1'b1;
          state_d = S_FETCH;
`ifdef SM_ROM_READER_CHECKSUM_EN
          csum_d       = 8'h00;
          csum_phase_d = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        byte_d     = bus.im_rd[7:0];
        rest_d     = bus.im_rd[31:8];
        byte_idx_d = 2'd0;
        cnt_d      = '0;
        uart_d     = 1'b0;
        state_d    = S_START;
`ifdef SM_ROM_READER_CHECKSUM_EN
        csum_d = csum_q ^ bus.im_rd[7:0] ^ bus.im_rd[15:8]
                        ^ bus.im_rd[23:16] ^ bus.im_rd[31:24];
`endif
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          uart_d  = byte_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            uart_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d  = bit_q + 1'b1;
            byte_d = {1'b0, byte_q[7:1]};
            uart_d = byte_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
`ifdef SM_ROM_READER_CHECKSUM_EN
          if (csum_phase_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else
`endif
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 1'b1;
            byte_d     = rest_q[7:0];
            rest_d     = {8'h00, rest_q[23:8]};
            uart_d     = 1'b0;
            state_d    = S_START;
          end else if (addr_q != end_q) begin
            addr_d  = addr_q + 1'b1;   // wraps naturally at 2^ADDR_W
            state_d = S_FETCH;
          end else begin
`ifdef SM_ROM_READER_CHECKSUM_EN
            csum_phase_d = 1'b1;
            byte_idx_d   = 2'd0;
            byte_d       = csum_q;
            uart_d       = 1'b0;
            state_d      = S_START;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      rest_q     <= '0;
      byte_q     <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      uart_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SM_ROM_READER_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      rest_q     <= rest_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      uart_q     <= uart_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SM_ROM_READER_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign bus.im_ra    = addr_q;
  assign bus.uart_out = uart_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.byteIdx  = byte_idx_q;

endmodule

// File: tb/tb_sm_rom_reader.sv
// tb_sm_rom_reader: directed bench for sm_rom_reader (BAUD_DIV=4, ADDR_W=11).
// Each dump is recorded cycle by cycle from cycle 1 (the cycle after the
// start sampling edge), then the UART line is decoded and compared against
// hand-computed byte streams, addresses and done/busy timing.
module tb_sm_rom_reader;

  localparam int B    = 4;
  localparam int MAXC = 900;
`ifdef SM_ROM_READER_CHECKSUM_EN
  localparam int EXTRA = 40;
`else
  localparam int EXTRA = 0;
`endif

  logic clkIn = 1'b0;
  logic rst_n;
  always #5 clkIn = ~clkIn;

  sm_rom_reader_if #(.ADDR_W(11)) bus ();
  sm_rom_reader #(.ADDR_W(11), .BAUD_DIV(B)) dut (
    .clkIn(clkIn),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clkIn) bus.im_rd <= mem[bus.im_ra];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_b [0:31];
  int          exp_n;
  logic [10:0] exp_a [0:15];
  int          exp_na;

  logic        ln [0:1023];
  logic        bz [0:1023];
  logic        dn [0:1023];
  logic [1:0]  bi [0:1023];
  logic [10:0] ra [0:1023];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts a dump, records it, then checks stream and timing.
  // poke > 0 re-pulses start (with a different address) at that cycle.
  task automatic run_dump(input logic [10:0] sa, input logic [10:0] la,
                          input int exp_done, input int poke);
    int k, dc, done_cyc, ndone, busy_low, i, nb, glitch, first_start, na;
    logic [7:0]  gb [0:31];
    logic [1:0]  gi [0:31];
    logic [10:0] ga [0:15];
    for (int j = 0; j < 1024; j++) begin
      ln[j] = 1'b1; bz[j] = 1'b0; dn[j] = 1'b0; bi[j] = 2'd0; ra[j] = '0;
    end
    for (int j = 0; j < 32; j++) begin gb[j] = 8'h00; gi[j] = 2'd0; end
    for (int j = 0; j < 16; j++) ga[j] = '0;
    bus.startAddr = sa;
    bus.lastAddr  = la;
    bus.start     = 1'b1;
    @(posedge clkIn); #1;
    bus.start = 1'b0;
    done_cyc = -1;
    k = 1;
    while (k < MAXC && !(done_cyc > 0 && k > done_cyc + 3)) begin
      ln[k] = bus.uart_out; bz[k] = bus.busy; dn[k] = bus.done;
      bi[k] = bus.byteIdx;  ra[k] = bus.im_ra;
      if (bus.done && done_cyc < 0) done_cyc = k;
      if (k == poke) begin
        bus.start = 1'b1; bus.startAddr = 11'd100; bus.lastAddr = 11'd100;
      end
      @(posedge clkIn); #1;
      bus.start = 1'b0;
      k++;
    end

    // Decode the line: each character must be 10 slots of exactly B equal samples.
    i = 1; nb = 0; glitch = 0; first_start = -1;
    while (i < k && nb < 32) begin
      if (ln[i] == 1'b0) begin
        logic [7:0] v;
        v = 8'h00;
        if (first_start < 0) first_start = i;
        gi[nb] = bi[i];
        for (int s = 0; s < 10; s++) begin
          for (int t = 1; t < B; t++)
            if (ln[i + s*B + t] != ln[i + s*B]) glitch++;
          if (s >= 1 && s <= 8) v[s-1] = ln[i + s*B];
        end
        if (ln[i + 9*B] != 1'b1) glitch++;
        gb[nb] = v;
        nb++;
        i += 10*B;
      end else begin
        i++;
      end
    end

    dc = (done_cyc > 0) ? done_cyc : 1;
    ndone = 0; busy_low = 0;
    for (int j = 1; j < k; j++) if (dn[j]) ndone++;
    for (int j = 1; j <= dc; j++) if (!bz[j]) busy_low++;
    na = 0;
    for (int j = 1; j <= dc; j++)
      if ((j == 1 || ra[j] != ra[j-1]) && na < 16) begin ga[na] = ra[j]; na++; end

    chk("busy_cycle1",    32'(bz[1]), 32'd1);
    chk("line_idle_c2",   32'(ln[2]), 32'd1);
    chk("start_bit_cyc",  32'(first_start), 32'd3);
    chk("done_cycle",     32'(done_cyc), 32'(exp_done));
    chk("done_width",     32'(ndone), 32'd1);
    chk("busy_gap",       32'(busy_low), 32'd0);
    chk("busy_after_done", 32'(bz[dc+1]), 32'd0);
    chk("bit_timing",     32'(glitch), 32'd0);
    chk("byte_count",     32'(nb), 32'(exp_n));
    for (int j = 0; j < exp_n; j++) begin
      chk($sformatf("byte%0d", j), 32'(gb[j]), 32'(exp_b[j]));
      chk($sformatf("byteIdx%0d", j), 32'(gi[j]),
          (j < 4*exp_na) ? 32'(j % 4) : 32'd0);
    end
    chk("addr_count", 32'(na), 32'(exp_na));
    for (int j = 0; j < exp_na; j++)
      chk($sformatf("im_ra%0d", j), 32'(ga[j]), 32'(exp_a[j]));
  endtask

  task automatic set_bytes4(input int base, input logic [31:0] w);
    exp_b[base]   = w[7:0];
    exp_b[base+1] = w[15:8];
    exp_b[base+2] = w[23:16];
    exp_b[base+3] = w[31:24];
  endtask

  initial begin
    for (int j = 0; j < 2048; j++) mem[j] = 32'h0;
    mem[5]    = 32'h12345678;
    mem[2047] = 32'hAABBCCDD;
    mem[0]    = 32'h00000001;
    mem[100]  = 32'h01020304;
    mem[101]  = 32'h80402010;
    mem[102]  = 32'hA5A55A5A;
    mem[200]  = 32'hCAFEF00D;
    mem[201]  = 32'h55AA55AA;
    mem[7]    = 32'hDEADBEEF;

    bus.start = 1'b0; bus.startAddr = '0; bus.lastAddr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
    chk("rst_uart",    32'(bus.uart_out), 32'd1);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_done",    32'(bus.done), 32'd0);
    chk("rst_byteIdx", 32'(bus.byteIdx), 32'd0);
    chk("rst_im_ra",   32'(bus.im_ra), 32'd0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clkIn);
    #1;

    // Single word 0x12345678 at address 5.
    set_bytes4(0, 32'h12345678); exp_n = 4;
`ifdef SM_ROM_READER_CHECKSUM_EN
    exp_b[4] = 8'h08; exp_n = 5;
`endif
    exp_a[0] = 11'd5; exp_na = 1;
    run_dump(11'd5, 11'd5, 163 + EXTRA, 0);

    // Same dump, start re-pulsed at cycle 50 must be ignored.
    run_dump(11'd5, 11'd5, 163 + EXTRA, 50);

    // Wrap through the top of memory: 2047 then 0.
    set_bytes4(0, 32'hAABBCCDD); set_bytes4(4, 32'h00000001); exp_n = 8;
`ifdef SM_ROM_READER_CHECKSUM_EN
    exp_b[8] = 8'h01; exp_n = 9;
`endif
    exp_a[0] = 11'd2047; exp_a[1] = 11'd0; exp_na = 2;
    run_dump(11'd2047, 11'd0, 325 + EXTRA, 0);

    // Three-word dump.
    set_bytes4(0, 32'h01020304); set_bytes4(4, 32'h80402010);
    set_bytes4(8, 32'hA5A55A5A); exp_n = 12;
`ifdef SM_ROM_READER_CHECKSUM_EN
    exp_b[12] = 8'hF4; exp_n = 13;
`endif
    exp_a[0] = 11'd100; exp_a[1] = 11'd101; exp_a[2] = 11'd102; exp_na = 3;
    run_dump(11'd100, 11'd102, 487 + EXTRA, 0);

    // Reset during DATA of byte 2, then a fresh dump from address 7.
    bus.startAddr = 11'd200; bus.lastAddr = 11'd201; bus.start = 1'b1;
    @(posedge clkIn); #1;
    bus.start = 1'b0;
    repeat (94) @(posedge clkIn);
    #1;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_byteIdx", 32'(bus.byteIdx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_uart", 32'(bus.uart_out), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_byteIdx", 32'(bus.byteIdx), 32'd0);
    chk("mid_rst_im_ra", 32'(bus.im_ra), 32'd0);
    repeat (2) @(posedge clkIn);
    #3 rst_n = 1'b1;
    @(posedge clkIn); #1;

    set_bytes4(0, 32'hDEADBEEF); exp_n = 4;
`ifdef SM_ROM_READER_CHECKSUM_EN
    exp_b[4] = 8'h22; exp_n = 5;
`endif
    exp_a[0] = 11'd7; exp_na = 1;
    run_dump(11'd7, 11'd7, 163 + EXTRA, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
